// File: rtl/pong_pkg.sv
// pong_pkg: screen geometry, ball constants, ball FSM states and frame-tick decode
package pong_pkg;
    localparam logic [9:0] X_MAX        = 10'd639;
    localparam logic [9:0] Y_MAX        = 10'd479;
    localparam logic [9:0] REFRESH_LINE = 10'd481;
    localparam logic [9:0] BALL_SIZE    = 10'd8;
    localparam logic [9:0] BALL_VEL     = 10'd2;
    typedef enum logic [1:0] {WAIT, PLAY, SCORED} ball_state_t;
    function automatic logic refresh_tick(input logic [9:0] x, input logic [9:0] y);
        return (y == REFRESH_LINE) && (x == 10'd0);
    endfunction
endpackage

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball movement, wall/paddle bounces, miss detection and score events
module ball_motion
    import pong_pkg::*;
#(
    parameter logic [9:0] X_START    = 10'd316,
    parameter logic [9:0] Y_START    = 10'd236,
    parameter int         SCORE_HOLD = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] pad1_t,
    input  logic [9:0] pad1_b,
    input  logic [9:0] pad1_l,
    input  logic [9:0] pad1_r,
    input  logic [9:0] pad2_t,
    input  logic [9:0] pad2_b,
    input  logic [9:0] pad2_l,
    input  logic [9:0] pad2_r,
    input  logic       serve,
    output logic [9:0] ball_l,
    output logic [9:0] ball_r,
    output logic [9:0] ball_t,
    output logic [9:0] ball_b,
    output logic       ball_on,
    output logic       hit_tick,
    output logic       score1_tick,
    output logic       score2_tick,
    output logic       playing
);
    ball_state_t r_state;
    logic [9:0]  r_bx, r_by;
    logic        r_dx_pos, r_dy_pos, r_serve_right;
    logic [5:0]  r_hold;
    logic        r_hit_tick, r_score1_tick, r_score2_tick;
    logic        w_refresh, w_hit_r, w_hit_l, w_hit, w_miss_r, w_miss_l, w_dx_n, w_dy_n;
    logic [9:0]  w_bx_n, w_by_n;

    assign w_refresh = refresh_tick(x, y);
    assign ball_l    = r_bx;
    assign ball_t    = r_by;
    assign ball_r    = r_bx + BALL_SIZE - 10'd1;
    assign ball_b    = r_by + BALL_SIZE - 10'd1;
    assign w_hit_r   = r_dx_pos && pad1_l <= ball_r && ball_r <= pad1_r && ball_b >= pad1_t && ball_t <= pad1_b;
    assign w_hit_l   = !r_dx_pos && pad2_l <= ball_l && ball_l <= pad2_r && ball_b >= pad2_t && ball_t <= pad2_b;
    assign w_hit     = w_hit_r || w_hit_l;
    assign w_miss_r  = r_dx_pos && ball_r >= X_MAX - BALL_VEL;
    assign w_miss_l  = !r_dx_pos && ball_l <= BALL_VEL;
    // Moves use the directions decided in the same tick, so a bounce never lets the ball cross a wall.
    assign w_dy_n    = (ball_t < BALL_VEL) ? 1'b1 : (ball_b > Y_MAX - BALL_VEL) ? 1'b0 : r_dy_pos;
    assign w_dx_n    = w_hit_r ? 1'b0 : w_hit_l ? 1'b1 : r_dx_pos;
    assign w_bx_n    = w_dx_n ? r_bx + BALL_VEL : r_bx - BALL_VEL;
    assign w_by_n    = w_dy_n ? r_by + BALL_VEL : r_by - BALL_VEL;
    assign ball_on   = r_state != SCORED && x >= ball_l && x <= ball_r && y >= ball_t && y <= ball_b;
    assign playing   = r_state == PLAY;
    assign hit_tick    = r_hit_tick;
    assign score1_tick = r_score1_tick;
    assign score2_tick = r_score2_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= WAIT;
            r_bx          <= X_START;
            r_by          <= Y_START;
            r_dx_pos      <= 1'b1;
            r_dy_pos      <= 1'b0;
            r_serve_right <= 1'b1;
            r_hold        <= 6'd0;
            r_hit_tick    <= 1'b0;
            r_score1_tick <= 1'b0;
            r_score2_tick <= 1'b0;
        end else begin
            r_hit_tick    <= 1'b0;
            r_score1_tick <= 1'b0;
            r_score2_tick <= 1'b0;
            case (r_state)
                WAIT: if (serve) begin
                    r_state  <= PLAY;
                    r_dx_pos <= r_serve_right;
                    r_dy_pos <= 1'b0;
                end
                PLAY: if (w_refresh) begin
                    if (!w_hit && w_miss_r) begin
                        r_score2_tick <= 1'b1;
                        r_serve_right <= 1'b1;
                        r_state       <= SCORED;
                    end else if (!w_hit && w_miss_l) begin
                        r_score1_tick <= 1'b1;
                        r_serve_right <= 1'b0;
                        r_state       <= SCORED;
                    end else begin
                        r_hit_tick <= w_hit;
                        r_dx_pos   <= w_dx_n;
                        r_dy_pos   <= w_dy_n;
                        r_bx       <= w_bx_n;
                        r_by       <= w_by_n;
                    end
                end
                SCORED: if (w_refresh) begin
                    if (r_hold == 6'(SCORE_HOLD - 1)) begin
                        r_state <= WAIT;
                        r_bx    <= X_START;
                        r_by    <= Y_START;
                        r_hold  <= 6'd0;
                    end else
                        r_hold <= r_hold + 6'd1;
                end
                default: r_state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized rally bench against a frame-level reference model of the ball
module tb_ball_motion;
    logic       clk = 1'b0, reset = 1'b1, serve = 1'b0;
    logic [9:0] x = 10'd700, y = 10'd0;
    logic [9:0] pad1_t = 10'd0, pad1_b = 10'd63, pad1_l = 10'd600, pad1_r = 10'd603;
    logic [9:0] pad2_t = 10'd0, pad2_b = 10'd63, pad2_l = 10'd36, pad2_r = 10'd39;
    logic [9:0] ball_l, ball_r, ball_t, ball_b;
    logic       ball_on, hit_tick, score1_tick, score2_tick, playing;

    int tests = 0, fails = 0;
    int m_mode, m_bx, m_by, m_vx, m_vy, m_srv, m_hold;
    bit m_hit, m_s1, m_s2;
    int n_hit = 0, n_s1 = 0, n_s2 = 0;
    bit en_serve = 0, miss1 = 0, miss2 = 0, force_miss = 0;

    ball_motion dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .pad1_t(pad1_t), .pad1_b(pad1_b), .pad1_l(pad1_l), .pad1_r(pad1_r),
        .pad2_t(pad2_t), .pad2_b(pad2_b), .pad2_l(pad2_l), .pad2_r(pad2_r),
        .serve(serve), .ball_l(ball_l), .ball_r(ball_r), .ball_t(ball_t), .ball_b(ball_b),
        .ball_on(ball_on), .hit_tick(hit_tick), .score1_tick(score1_tick),
        .score2_tick(score2_tick), .playing(playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_bx = 316; m_by = 236; m_vx = 1; m_vy = -1; m_srv = 1; m_hold = 0;
        m_hit = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_serve();
        if (m_mode == 0) begin
            m_mode = 1; m_vx = m_srv; m_vy = -1;
        end
    endtask

    // One frame of game physics in velocity terms: signed steps of 2 px per axis.
    task automatic model_frame();
        int l, r, t, b, nvx, nvy;
        bit hr, hl;
        m_hit = 0; m_s1 = 0; m_s2 = 0;
        if (m_mode == 1) begin
            l = m_bx; r = m_bx + 7; t = m_by; b = m_by + 7;
            nvy = (t < 2) ? 1 : (b > 477) ? -1 : m_vy;
            hr = m_vx > 0 && r >= int'(pad1_l) && r <= int'(pad1_r) && b >= int'(pad1_t) && t <= int'(pad1_b);
            hl = m_vx < 0 && l >= int'(pad2_l) && l <= int'(pad2_r) && b >= int'(pad2_t) && t <= int'(pad2_b);
            nvx = hr ? -1 : hl ? 1 : m_vx;
            if (!hr && !hl && m_vx > 0 && r >= 637) begin
                m_s2 = 1; m_srv = 1; m_mode = 2; n_s2++;
            end else if (!hr && !hl && m_vx < 0 && l <= 2) begin
                m_s1 = 1; m_srv = -1; m_mode = 2; n_s1++;
            end else begin
                if (hr || hl) begin m_hit = 1; n_hit++; end
                m_vx = nvx; m_vy = nvy;
                m_bx += 2 * m_vx; m_by += 2 * m_vy;
            end
        end else if (m_mode == 2) begin
            if (m_hold == 59) begin
                m_mode = 0; m_bx = 316; m_by = 236; m_hold = 0;
            end else m_hold++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_bl"}, ball_l, m_bx);
        check({tag, "_bt"}, ball_t, m_by);
        check({tag, "_br"}, ball_r, m_bx + 7);
        check({tag, "_bb"}, ball_b, m_by + 7);
        check({tag, "_play"}, playing, m_mode == 1);
    endtask

    task automatic frame();
        bit s;
        y = 10'd481; x = 10'd0;
        @(posedge clk); #1;
        model_frame();
        y = 10'd0; x = 10'd700;
        check_state("frm");
        check("hit_tick", hit_tick, m_hit);
        check("score1_tick", score1_tick, m_s1);
        check("score2_tick", score2_tick, m_s2);
        if (m_hit || m_s1 || m_s2) begin
            miss1 = force_miss || $urandom_range(0, 3) == 0;
            miss2 = force_miss || $urandom_range(0, 3) == 0;
        end
        s = en_serve && $urandom_range(0, 3) == 0;
        serve = s;
        @(posedge clk); #1;
        serve = 1'b0;
        if (s) model_serve();
        check("tick_clear", {hit_tick, score1_tick, score2_tick}, 0);
        check("play2", playing, m_mode == 1);
    endtask

    task automatic probe(input int px, input int py, input bit exp);
        x = 10'(px); y = 10'(py);
        #1;
        check("ball_on", ball_on, exp);
        x = 10'd700; y = 10'd0;
    endtask

    task automatic probe_rand();
        int px, py;
        px = m_bx + $urandom_range(0, 13) - 3;
        py = m_by + $urandom_range(0, 13) - 3;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px == 0 && py == 481) px = 1;
        probe(px, py, m_mode != 2 && px >= m_bx && px <= m_bx + 7 && py >= m_by && py <= m_by + 7);
    endtask

    // Paddles either track the ball (hit) or sit clear of it (miss).
    function automatic int pad_top(input bit miss);
        int t;
        if (miss) return (m_by > 200) ? 0 : 400;
        t = m_by - int'($urandom_range(0, 40));
        if (t < 0) t = 0;
        if (t > 416) t = 416;
        return t;
    endfunction

    task automatic set_pads();
        pad1_t = 10'(pad_top(miss1)); pad1_b = pad1_t + 10'd63;
        pad2_t = 10'(pad_top(miss2)); pad2_b = pad2_t + 10'd63;
    endtask

    task automatic do_serve();
        serve = 1'b1;
        @(posedge clk); #1;
        serve = 1'b0;
        model_serve();
        check("serve_play", playing, 1);
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst");
        check("rst_ticks", {hit_tick, score1_tick, score2_tick}, 0);
        reset = 1'b0;
        repeat (3) frame();
        check("wait_bl", ball_l, 316);
        check("wait_bt", ball_t, 236);
        probe(316, 236, 1);
        probe(323, 243, 1);
        probe(315, 236, 0);
        probe(324, 240, 0);
        probe(320, 244, 0);
        probe(320, 235, 0);

        do_serve();
        frame();
        check("serve_bx", ball_l, 318);
        check("serve_by", ball_t, 234);

        en_serve = 1;
        for (int i = 0; i < 3000; i++) begin
            set_pads();
            frame();
            probe_rand();
        end
        check("saw_hit", n_hit > 0, 1);
        check("saw_score1", n_s1 > 0, 1);
        check("saw_score2", n_s2 > 0, 1);

        force_miss = 1; miss1 = 1; miss2 = 1;
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            set_pads();
            frame();
            reached = (m_mode == 2 && m_hold == 30);
        end
        check("reach_hold30", reached, 1);
        en_serve = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_state("mid_rst");
        check("mid_rst_ticks", {hit_tick, score1_tick, score2_tick}, 0);
        probe(320, 240, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_rst_ticks", {hit_tick, score1_tick, score2_tick}, 0);
        do_serve();
        frame();
        check("rst_serve_bx", ball_l, 318);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
